twiddle_issue: RTL and testbench

Operand issuer for the complex multiplier in the FFT datapath: accepts one frame of complex samples over a valid/ready stream and pairs each sample with the correct twiddle factor for the selected butterfly stage. It presents aligned operands to the multiplier (a/b = sample real/imag, c/d = twiddle real/imag) and regenerates a result-valid strobe matched to the multiplier pipeline latency. Twiddle factors sit in an internal RAM loaded through a write port.

---
 rtl/twiddle_issue.sv | 105 ++++++++++
 tb/tb_twiddle_issue.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/twiddle_issue.sv
// twiddle_issue: pairs each frame sample with its stage twiddle for the complex multiplier.
// Optional TWIDDLE_CONJ_EN: issue the conjugate twiddle (d = -tw_im, saturating) for the IFFT.
module twiddle_issue #(
  parameter int LOG2N    = 4,
  parameter int MULT_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    tw_we,
  input  logic [LOG2N-1:0]        tw_addr,
  input  logic signed [17:0]      tw_re,
  input  logic signed [17:0]      tw_im,
  input  logic                    start,
  input  logic [3:0]              stage,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [31:0]      s_re,
  input  logic signed [31:0]      s_im,
  output logic signed [31:0]      a,
  output logic signed [31:0]      b,
  output logic signed [17:0]      c,
  output logic signed [17:0]      d,
  output logic                    op_valid,
  output logic                    res_valid,
  output logic                    busy,
  output logic                    done
);
  localparam int N = 1 << LOG2N;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [3:0] stg;
  logic [LOG2N-1:0] n, mask, k;
  logic [MULT_LAT-1:0] sr;
  logic [MULT_LAT:0] pipe;
  logic accept, last_res;
  logic signed [17:0] ram_re [N];
  logic signed [17:0] ram_im [N];
  logic signed [17:0] tw_d;
  always_comb begin
    accept = state == RUN && s_valid && s_ready;
    mask = LOG2N'((1 << stg) - 1);
    k = (n & mask) << (4'(LOG2N - 1) - stg);
    pipe = {sr, op_valid};
    // next cycle's res_valid is the only one still in flight
    last_res = state == DRAIN && pipe[MULT_LAT-1:0] == (MULT_LAT'(1) << (MULT_LAT - 1));
`ifdef TWIDDLE_CONJ_EN
    tw_d = ram_im[k] == 18'sh20000 ? 18'sh1ffff : -ram_im[k];
`else
    tw_d = ram_im[k];
`endif
  end
  assign res_valid = sr[MULT_LAT-1];
  always_ff @(posedge clk) begin
    if (tw_we && state == IDLE) begin
      ram_re[tw_addr] <= tw_re;
      ram_im[tw_addr] <= tw_im;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      stg      <= '0;
      n        <= '0;
      sr       <= '0;
      s_ready  <= 1'b0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      d        <= '0;
    end else begin
      sr       <= pipe[MULT_LAT-1:0];
      op_valid <= accept;
      done     <= last_res;
      if (accept) begin
        a <= s_re;
        b <= s_im;
        c <= ram_re[k];
        d <= tw_d;
        n <= n + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            stg     <= stage >= 4'(LOG2N) ? 4'(LOG2N - 1) : stage;
            n       <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end else busy <= 1'b0;
        end
        RUN: begin
          if (accept && n == LOG2N'(N - 1)) begin
            state   <= DRAIN;
            s_ready <= 1'b0;
          end
        end
        DRAIN: if (last_res) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_twiddle_issue.sv
// tb_twiddle_issue: directed frames with a scoreboard on operands and a latency queue on res_valid.
module tb_twiddle_issue;
  localparam int LOG2N = 4, N = 16, L = 3;
  logic clk = 0, rstn = 0;
  logic tw_we = 0, start = 0, s_valid = 0;
  logic [LOG2N-1:0] tw_addr = '0;
  logic signed [17:0] tw_re = '0, tw_im = '0;
  logic [3:0] stage = '0;
  logic signed [31:0] s_re = '0, s_im = '0;
  logic s_ready, op_valid, res_valid, busy, done;
  logic signed [31:0] a, b;
  logic signed [17:0] c, d;
  typedef struct packed {
    logic signed [31:0] a, b;
    logic signed [17:0] c, d;
  } op_t;
  op_t eq[$];
  int rq[$];
  int tot = 0, bad = 0, cyc = 0, res_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic signed [17:0] m_re [N];
  logic signed [17:0] m_im [N];

  twiddle_issue #(.LOG2N(LOG2N), .MULT_LAT(L)) dut (
    .clk(clk), .rstn(rstn), .tw_we(tw_we), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .start(start), .stage(stage), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .a(a), .b(b), .c(c), .d(d), .op_valid(op_valid), .res_valid(res_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic signed [17:0] exp_d(input logic signed [17:0] im);
`ifdef TWIDDLE_CONJ_EN
    return im == 18'sh20000 ? 18'sh1ffff : -im;
`else
    return im;
`endif
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (res_valid) begin
        res_cnt++;
        chk("res_pending", rq.size() != 0, 1);
        if (rq.size() != 0) chk("res_latency", cyc, rq.pop_front());
      end
      if (op_valid) begin
        chk("op_pending", eq.size() != 0, 1);
        if (eq.size() != 0) chk("operands", {a, b, c, d}, eq.pop_front());
        rq.push_back(cyc + L);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_align", {res_valid, busy, rq.size() == 0}, 3'b111);
      end
    end
  end

  task automatic twrite(input int addr, input int re, input int im);
    @(posedge clk); #1;
    tw_we = 1; tw_addr = LOG2N'(addr); tw_re = 18'(re); tw_im = 18'(im);
    m_re[addr] = 18'(re); m_im[addr] = 18'(im);
    @(posedge clk); #1;
    tw_we = 0;
  endtask

  task automatic frame(input int stg, input bit gap, input int stop_after, input bit poke);
    int st, n, cnt, s_cyc, last_cyc, rc, k, w;
    op_t e;
    st = stg >= LOG2N ? LOG2N - 1 : stg;
    n = 0; cnt = 0; last_cyc = 0; w = 0;
    rc = done_cnt;
    @(posedge clk); #1;
    start = 1; stage = 4'(stg); s_cyc = cyc;
    @(negedge clk);
    chk("busy_before", busy, 0);
    @(posedge clk); #1;
    start = 0; res_cnt = 0;
    while (n < N && n < stop_after && cnt < 200) begin
      s_valid = !(gap && cnt % 2 == 1);
      s_re = n; s_im = stg * 100 - n;
      if (poke && n == 3) begin
        start = 1; tw_we = 1; tw_addr = '0; tw_re = 18'sd99; tw_im = 18'sd99;
      end
      @(negedge clk);
      if (cnt == 0) chk("busy_run", busy, 1);
      if (s_valid && s_ready) begin
        k = (n & ((1 << st) - 1)) << (LOG2N - 1 - st);
        e.a = n; e.b = stg * 100 - n; e.c = m_re[k]; e.d = exp_d(m_im[k]);
        eq.push_back(e);
        n++;
        last_cyc = cyc;
      end
      cnt++;
      @(posedge clk); #1;
      start = 0; tw_we = 0;
    end
    s_valid = 0;
    if (stop_after < N) return;
    chk("accepts", n, N);
    @(negedge clk);
    chk("ready_fall", s_ready, 0);
    while (done_cnt == rc && w < 60) begin
      @(posedge clk);
      w++;
    end
    chk("done_count", done_cnt - rc, 1);
    chk("done_cycle", done_cyc, last_cyc + 1 + L);
    if (!gap) chk("frame_time", done_cyc - s_cyc, N + 1 + L);
    chk("res_count", res_cnt, N);
    chk("sb_empty", eq.size(), 0);
    @(negedge clk);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_outputs", {s_ready, op_valid, res_valid, busy, done, a, b, c, d}, 0);
    @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < N; i++) twrite(i, i, -i);
    frame(0, 0, N, 0);
    frame(3, 0, N, 0);
    frame(1, 1, N, 0);
    frame(2, 0, 5, 0);
    rstn = 0;
    @(negedge clk);
    chk("midframe_reset", {s_ready, op_valid, res_valid, busy, done, a, b, c, d}, 0);
    eq.delete();
    rq.delete();
    @(posedge clk); #1;
    rstn = 1;
    frame(2, 0, N, 0);
    frame(3, 0, N, 1);
    frame(0, 0, N, 0);
    frame(9, 0, N, 0);
    twrite(0, 7, -131072);
    twrite(4, -3, 5);
    frame(1, 0, N, 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
